leaf_vote_stage: RTL and testbench

- Terminal stage of the decision-tree pipeline, directly downstream of internal_branch_stage.
- Takes a leaf node index from either of two parent branch outputs: port A is wired to a parent's bottom (validBottom/bottomRec) output, port B to a parent's right (validRight/rightRec) output.
- Arbitrates round-robin between them, fetches the leaf's class label from node memory and presents the label to the vote accumulator with a valid/receive handshake.
- Counts completed classifications.

---
 rtl/leaf_vote_stage.sv | 98 +++++++++
 tb/tb_leaf_vote_stage.sv | 318 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/leaf_vote_stage.sv
// rtl/leaf_vote_stage.sv - terminal tree stage: round-robin leaf pick, label fetch, vote handoff
// One leaf in flight; upstream ports see backpressure only through withheld rec pulses.
module leaf_vote_stage #(
    parameter int NUM_FEAT  = 2,
    parameter int NUM_NODES = 8,
    parameter int WIDTH     = 4,
    parameter int CLASS_W   = 4,
    localparam int IDX_W    = $clog2(NUM_NODES),
    localparam int DATA_W   = NUM_FEAT * WIDTH
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              validA,
    input  logic [IDX_W-1:0]  nodeIdxA,
    output logic              recA,
    input  logic              validB,
    input  logic [IDX_W-1:0]  nodeIdxB,
    output logic              recB,
    output logic [IDX_W-1:0]  memReqOut,
    output logic              reqRdy,
    input  logic              memRdy,
    input  logic [DATA_W-1:0] memData,
    input  logic              dataRdy,
    output logic              validOut,
    output logic [CLASS_W-1:0] classOut,
    output logic [IDX_W-1:0]  leafIdxOut,
    input  logic              outRec,
    output logic [15:0]       leafCount
);

    typedef enum logic [1:0] {IDLE, REQ, WAIT, OUT} state_t;

    state_t     state;
    logic       prio_b;
    logic       grant_a;
    logic [IDX_W-1:0] grant_idx;
    logic       data_unused;

    // Port B wins only when it is the sole requester or holds the priority pointer.
    assign grant_a   = validA && (!validB || !prio_b);
    assign grant_idx = grant_a ? nodeIdxA : nodeIdxB;

    // Only the low label bits of the node word matter at a leaf.
    assign data_unused = ^memData;

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            prio_b     <= 1'b0;
            recA       <= 1'b0;
            recB       <= 1'b0;
            reqRdy     <= 1'b0;
            memReqOut  <= '0;
            validOut   <= 1'b0;
            classOut   <= '0;
            leafIdxOut <= '0;
            leafCount  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (validA || validB) begin
                        memReqOut  <= grant_idx;
                        leafIdxOut <= grant_idx;
                        recA       <= grant_a;
                        recB       <= !grant_a;
                        prio_b     <= grant_a;
                        reqRdy     <= 1'b1;
                        state      <= REQ;
                    end
                end
                REQ: begin
                    recA <= 1'b0;
                    recB <= 1'b0;
                    if (memRdy) begin
                        reqRdy <= 1'b0;
                        state  <= WAIT;
                    end
                end
                WAIT: begin
                    if (dataRdy) begin
                        classOut <= memData[CLASS_W-1:0];
                        validOut <= 1'b1;
                        state    <= OUT;
                    end
                end
                OUT: begin
                    if (outRec) begin
                        validOut  <= 1'b0;
                        leafCount <= leafCount + 16'd1;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_leaf_vote_stage.sv
// tb/tb_leaf_vote_stage.sv - directed and randomized checks of leaf_vote_stage
module tb_leaf_vote_stage;

    logic       clk = 1'b0;
    logic       rst;
    logic       validA, validB, recA, recB;
    logic [2:0] nodeIdxA, nodeIdxB, memReqOut, leafIdxOut;
    logic       reqRdy, memRdy, dataRdy, validOut, outRec;
    logic [7:0] memData;
    logic [3:0] classOut;
    logic [15:0] leafCount;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    leaf_vote_stage dut (
        .clk(clk), .rst(rst),
        .validA(validA), .nodeIdxA(nodeIdxA), .recA(recA),
        .validB(validB), .nodeIdxB(nodeIdxB), .recB(recB),
        .memReqOut(memReqOut), .reqRdy(reqRdy), .memRdy(memRdy),
        .memData(memData), .dataRdy(dataRdy),
        .validOut(validOut), .classOut(classOut), .leafIdxOut(leafIdxOut),
        .outRec(outRec), .leafCount(leafCount)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        validA = 0; validB = 0; nodeIdxA = 0; nodeIdxB = 0;
        memRdy = 0; dataRdy = 0; memData = 0; outRec = 0;
    endtask

    task automatic do_reset();
        clear_inputs();
        rst = 1;
        step();
        rst = 0;
    endtask

    task automatic test_reset();
        logic [42:0] outs;
        do_reset();
        outs = {recA, recB, reqRdy, memReqOut, validOut, classOut, leafIdxOut, leafCount, 8'h00};
        checks++;
        if (outs !== 43'd0) begin
            errors++;
            $display("FAIL reset_outputs got=%h want=0", outs);
        end
        for (int i = 0; i < 10; i++) begin
            step();
            checks++;
            if (reqRdy !== 1'b0 || validOut !== 1'b0 || recA !== 1'b0 || recB !== 1'b0) begin
                errors++;
                $display("FAIL idle_quiet cyc=%0d reqRdy=%b validOut=%b rec=%b%b want all 0",
                         i, reqRdy, validOut, recA, recB);
            end
        end
    endtask

    task automatic test_single_a();
        do_reset();
        nodeIdxA = 3'd5; validA = 1; memRdy = 1; dataRdy = 1; memData = 8'h1A; outRec = 1;
        step();
        checks++;
        if ({recA, recB, reqRdy, memReqOut} !== {1'b1, 1'b0, 1'b1, 3'd5}) begin
            errors++;
            $display("FAIL single_accept got rec=%b%b reqRdy=%b addr=%0d want rec=10 reqRdy=1 addr=5",
                     recA, recB, reqRdy, memReqOut);
        end
        validA = 0;
        step();
        checks++;
        if ({recA, reqRdy, validOut} !== 3'b000) begin
            errors++;
            $display("FAIL single_req_done got recA=%b reqRdy=%b validOut=%b want 000", recA, reqRdy, validOut);
        end
        step();
        checks++;
        if ({validOut, classOut, leafIdxOut} !== {1'b1, 4'hA, 3'd5}) begin
            errors++;
            $display("FAIL single_result got v=%b class=%h leaf=%0d want v=1 class=a leaf=5",
                     validOut, classOut, leafIdxOut);
        end
        step();
        checks++;
        if (validOut !== 1'b0 || leafCount !== 16'd1) begin
            errors++;
            $display("FAIL single_count got v=%b count=%0d want v=0 count=1", validOut, leafCount);
        end
        clear_inputs();
    endtask

    task automatic test_simultaneous();
        logic [3:0] got[$];
        logic [3:0] want[4];
        want[0] = {1'b0, 3'd2}; want[1] = {1'b1, 3'd6};
        want[2] = {1'b0, 3'd2}; want[3] = {1'b1, 3'd6};
        do_reset();
        memRdy = 1; dataRdy = 1; outRec = 1; memData = 8'h44;
        for (int round = 0; round < 2; round++) begin
            validA = 1; nodeIdxA = 3'd2; validB = 1; nodeIdxB = 3'd6;
            for (int c = 0; c < 30 && (validA || validB); c++) begin
                step();
                if (recA) begin got.push_back({1'b0, memReqOut}); validA = 0; end
                if (recB) begin got.push_back({1'b1, memReqOut}); validB = 0; end
            end
            while (validOut || reqRdy) step();
            step();
        end
        checks++;
        if (got.size() != 4) begin
            errors++;
            $display("FAIL simul_grant_count got=%0d want=4", got.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                checks++;
                if (got[i] !== want[i]) begin
                    errors++;
                    $display("FAIL simul_grant%0d got port=%0d idx=%0d want port=%0d idx=%0d",
                             i, got[i][3], got[i][2:0], want[i][3], want[i][2:0]);
                end
            end
        end
        clear_inputs();
    endtask

    task automatic test_mem_stall();
        do_reset();
        validA = 1; nodeIdxA = 3'd3;
        step();
        validA = 0; validB = 1; nodeIdxB = 3'd4; dataRdy = 1; memData = 8'h99;
        for (int i = 0; i < 5; i++) begin
            step();
            checks++;
            if ({reqRdy, memReqOut, recA, recB, validOut} !== {1'b1, 3'd3, 3'b000}) begin
                errors++;
                $display("FAIL stall_hold cyc=%0d got reqRdy=%b addr=%0d rec=%b%b v=%b want 1 3 00 0",
                         i, reqRdy, memReqOut, recA, recB, validOut);
            end
        end
        dataRdy = 0; memRdy = 1;
        step();
        memRdy = 0;
        step();
        step();
        checks++;
        if (reqRdy !== 1'b0 || validOut !== 1'b0) begin
            errors++;
            $display("FAIL stall_wait got reqRdy=%b v=%b want 0 0", reqRdy, validOut);
        end
        dataRdy = 1; memData = 8'h27;
        step();
        dataRdy = 0;
        checks++;
        if ({validOut, classOut, leafIdxOut} !== {1'b1, 4'h7, 3'd3}) begin
            errors++;
            $display("FAIL stall_result got v=%b class=%h leaf=%0d want 1 7 3", validOut, classOut, leafIdxOut);
        end
        outRec = 1;
        step();
        outRec = 0;
        step();
        checks++;
        if (recB !== 1'b1 || memReqOut !== 3'd4) begin
            errors++;
            $display("FAIL stall_next_grant got recB=%b addr=%0d want 1 4", recB, memReqOut);
        end
        clear_inputs();
    endtask

    task automatic test_backpressure();
        do_reset();
        validA = 1; nodeIdxA = 3'd1; memRdy = 1; dataRdy = 1; memData = 8'h5C;
        step();
        validA = 0;
        step();
        step();
        validB = 1; nodeIdxB = 3'd2; dataRdy = 0; memData = 8'hFF;
        for (int i = 0; i < 4; i++) begin
            step();
            checks++;
            if ({validOut, classOut, leafIdxOut, recB} !== {1'b1, 4'hC, 3'd1, 1'b0}) begin
                errors++;
                $display("FAIL bp_hold cyc=%0d got v=%b class=%h leaf=%0d recB=%b want 1 c 1 0",
                         i, validOut, classOut, leafIdxOut, recB);
            end
        end
        outRec = 1;
        step();
        outRec = 0;
        checks++;
        if (validOut !== 1'b0 || recB !== 1'b0 || leafCount !== 16'd1) begin
            errors++;
            $display("FAIL bp_release got v=%b recB=%b count=%0d want 0 0 1", validOut, recB, leafCount);
        end
        step();
        checks++;
        if (recB !== 1'b1 || memReqOut !== 3'd2) begin
            errors++;
            $display("FAIL bp_next_grant got recB=%b addr=%0d want 1 2", recB, memReqOut);
        end
        clear_inputs();
    endtask

    task automatic test_reset_midflight();
        do_reset();
        validA = 1; nodeIdxA = 3'd6; memRdy = 1;
        step();
        validA = 0;
        step();
        rst = 1;
        step();
        rst = 0; dataRdy = 1; memData = 8'h03;
        for (int i = 0; i < 3; i++) begin
            step();
            checks++;
            if (validOut !== 1'b0 || reqRdy !== 1'b0 || leafCount !== 16'd0) begin
                errors++;
                $display("FAIL midreset_quiet cyc=%0d got v=%b reqRdy=%b count=%0d want 0 0 0",
                         i, validOut, reqRdy, leafCount);
            end
        end
        dataRdy = 0; validB = 1; nodeIdxB = 3'd7;
        step();
        checks++;
        if (recB !== 1'b1 || memReqOut !== 3'd7) begin
            errors++;
            $display("FAIL midreset_idle got recB=%b addr=%0d want 1 7", recB, memReqOut);
        end
        clear_inputs();
    endtask

    task automatic test_random();
        logic [7:0] mem_tbl[8];
        logic       ptr_b = 0;
        logic       busy = 0;
        logic       got_result = 0;
        logic [2:0] exp_idx = 0;
        logic       v_prev = 0, o_prev = 0;
        logic       exp_a;
        int         done_cnt = 0;
        for (int i = 0; i < 8; i++) mem_tbl[i] = 8'($urandom);
        do_reset();
        for (int cyc = 0; cyc < 3000; cyc++) begin
            step();
            if (v_prev && o_prev) begin
                busy = 0;
                done_cnt++;
            end
            if (recA || recB) begin
                exp_a = validA && (!validB || !ptr_b);
                checks++;
                if (busy || (recA && recB) || recA !== exp_a) begin
                    errors++;
                    $display("FAIL rand_grant cyc=%0d got rec=%b%b busy=%b want recA=%b",
                             cyc, recA, recB, busy, exp_a);
                end
                exp_idx = exp_a ? nodeIdxA : nodeIdxB;
                checks++;
                if (memReqOut !== exp_idx) begin
                    errors++;
                    $display("FAIL rand_addr cyc=%0d got=%0d want=%0d", cyc, memReqOut, exp_idx);
                end
                ptr_b = exp_a;
                busy = 1;
                got_result = 0;
                if (exp_a) validA = 0; else validB = 0;
            end
            if (validOut && !got_result) begin
                got_result = 1;
                checks++;
                if (!busy || classOut !== mem_tbl[exp_idx][3:0] || leafIdxOut !== exp_idx) begin
                    errors++;
                    $display("FAIL rand_result cyc=%0d got class=%h leaf=%0d want class=%h leaf=%0d",
                             cyc, classOut, leafIdxOut, mem_tbl[exp_idx][3:0], exp_idx);
                end
            end
            memRdy  = 1'($urandom_range(0, 1));
            dataRdy = 1'($urandom_range(0, 1));
            outRec  = 1'($urandom_range(0, 1));
            memData = mem_tbl[memReqOut];
            if (!validA && $urandom_range(0, 3) == 0) begin
                validA = 1; nodeIdxA = 3'($urandom);
            end
            if (!validB && $urandom_range(0, 3) == 0) begin
                validB = 1; nodeIdxB = 3'($urandom);
            end
            v_prev = validOut;
            o_prev = outRec;
        end
        checks++;
        if (done_cnt == 0 || leafCount !== 16'(done_cnt)) begin
            errors++;
            $display("FAIL rand_count got=%0d want=%0d", leafCount, done_cnt);
        end
        clear_inputs();
    endtask

    initial begin
        rst = 1;
        clear_inputs();
        test_reset();
        test_single_a();
        test_simultaneous();
        test_mem_stall();
        test_backpressure();
        test_reset_midflight();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
